// File: rtl/uart_tx_fifo.sv
// UART transmitter with configurable data width, parity and stop bits, fed by a
// small transmit FIFO with a valid/ready write port. Baud timing is generated internally.
module uart_tx_fifo #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 5208,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_W        = 13
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          bit_out,
    output logic                          busy,
    output logic                          isDone,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_TC    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [PTR_W:0]   COUNT_MAX = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [PTR_W:0]       count_q;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;

    logic                 push;
    logic                 pop;
    logic                 baud_tc;
    logic                 last_stop;
    logic                 frame_end;

    // Odd parity sets the bit when the data already holds an even number of ones.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
        if (PARITY == 1) begin
            return ~(^w);
        end
        return ^w;
    endfunction

    assign tx_ready   = (count_q != COUNT_MAX);
    assign fifo_count = count_q;
    assign push       = tx_valid && tx_ready;
    assign baud_tc    = (cnt_q == CNT_TC);
    assign last_stop  = (STOP_BITS == 1) || stop_idx_q;
    assign busy       = (state_q != S_IDLE);
    assign isDone     = frame_end;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        par_d      = par_q;
        pop        = 1'b0;
        frame_end  = 1'b0;

        if (state_q != S_IDLE) begin
            cnt_d = baud_tc ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    par_d   = parity_of(mem_q[rd_ptr_q]);
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_tc) begin
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_tc) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == BIT_LAST) begin
                        stop_idx_d = 1'b0;
                        state_d    = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (baud_tc) begin
                    stop_idx_d = 1'b0;
                    state_d    = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_tc) begin
                    if (last_stop) begin
                        frame_end = 1'b1;
                        // Back-to-back frames: reload straight into START with a fresh baud phase.
                        if (count_q != '0) begin
                            pop     = 1'b1;
                            shift_d = mem_q[rd_ptr_q];
                            par_d   = parity_of(mem_q[rd_ptr_q]);
                            cnt_d   = '0;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        case (state_q)
            S_START:  bit_out = 1'b0;
            S_DATA:   bit_out = shift_q[0];
            S_PARITY: bit_out = par_q;
            default:  bit_out = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage carries no reset; it is only read once the control side says it is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
        shift_q <= shift_d;
        par_q   <= par_d;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four configurations behind one observation mux, a
// frame-position reference model, a vector table and hand-written corner sequences.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_valid_c;
    logic [8:0] tx_data_c;
    logic [1:0] sel;

    logic       v   [4];
    logic       rdy [4];
    logic       bo  [4];
    logic       bsy [4];
    logic       dn  [4];
    logic [2:0] cnt [4];

    logic       obs_bit, obs_busy, obs_done, obs_ready;
    logic [2:0] obs_count;

    int c_db  [4] = '{8, 8, 8, 5};
    int c_par [4] = '{0, 1, 2, 0};
    int c_sb  [4] = '{1, 2, 2, 1};
    int c_cpb [4] = '{4, 4, 4, 3};

    int n_cmp  = 0;
    int n_fail = 0;

    int mq[$];
    bit m_active;
    int m_pos;
    int m_cur;

    typedef struct {
        logic [1:0]  sel;
        logic [8:0]  word;
        int          flen;
        logic [11:0] serial;
    } vec_t;
    vec_t tbl [4];

    always #5 clk = ~clk;

    assign v[0] = tx_valid_c && (sel == 2'd0);
    assign v[1] = tx_valid_c && (sel == 2'd1);
    assign v[2] = tx_valid_c && (sel == 2'd2);
    assign v[3] = tx_valid_c && (sel == 2'd3);

    uart_tx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4), .CNT_W(3)) d0 (
        .clk(clk), .rst(rst), .tx_data(tx_data_c[7:0]), .tx_valid(v[0]), .tx_ready(rdy[0]),
        .bit_out(bo[0]), .busy(bsy[0]), .isDone(dn[0]), .fifo_count(cnt[0]));
    uart_tx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4), .CNT_W(3)) d1 (
        .clk(clk), .rst(rst), .tx_data(tx_data_c[7:0]), .tx_valid(v[1]), .tx_ready(rdy[1]),
        .bit_out(bo[1]), .busy(bsy[1]), .isDone(dn[1]), .fifo_count(cnt[1]));
    uart_tx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4), .CNT_W(3)) d2 (
        .clk(clk), .rst(rst), .tx_data(tx_data_c[7:0]), .tx_valid(v[2]), .tx_ready(rdy[2]),
        .bit_out(bo[2]), .busy(bsy[2]), .isDone(dn[2]), .fifo_count(cnt[2]));
    uart_tx_fifo #(.DATA_BITS(5), .CLKS_PER_BIT(3), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4), .CNT_W(2)) d3 (
        .clk(clk), .rst(rst), .tx_data(tx_data_c[4:0]), .tx_valid(v[3]), .tx_ready(rdy[3]),
        .bit_out(bo[3]), .busy(bsy[3]), .isDone(dn[3]), .fifo_count(cnt[3]));

    always_comb begin
        obs_bit   = bo[sel];
        obs_busy  = bsy[sel];
        obs_done  = dn[sel];
        obs_ready = rdy[sel];
        obs_count = cnt[sel];
    end

    // Frame length in cycles for the selected configuration.
    function automatic int flen();
        return (1 + c_db[sel] + ((c_par[sel] != 0) ? 1 : 0) + c_sb[sel]) * c_cpb[sel];
    endfunction

    // Level of serial bit k of a frame carrying word w: start, data LSB first, optional parity, stops.
    function automatic bit fbit(input int w, input int k);
        int db;
        db = c_db[sel];
        if (k == 0) return 1'b0;
        if (k <= db) return bit'((w >> (k - 1)) & 1);
        if (c_par[sel] != 0 && k == db + 1) begin
            if (($countones(w) % 2) == 0) return (c_par[sel] == 1);
            return (c_par[sel] == 2);
        end
        return 1'b1;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (sel=%0d, t=%0t)", nm, act, exp, sel, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_active = 1'b0;
        m_pos    = 0;
        m_cur    = 0;
    endtask

    task automatic compare_all();
        check("bit_out", int'(obs_bit), m_active ? int'(fbit(m_cur, m_pos / c_cpb[sel])) : 1);
        check("busy", int'(obs_busy), int'(m_active));
        check("isDone", int'(obs_done), (m_active && m_pos == flen() - 1) ? 1 : 0);
        check("fifo_count", int'(obs_count), mq.size());
        check("tx_ready", int'(obs_ready), (mq.size() != 4) ? 1 : 0);
    endtask

    // One clock: model decides on pre-edge inputs, then outputs are compared at the falling edge.
    task automatic tick(input bit chk);
        bit acc, done, popnow;
        acc    = tx_valid_c && (mq.size() < 4);
        done   = m_active && (m_pos == flen() - 1);
        popnow = (!m_active || done) && (mq.size() != 0);
        @(posedge clk);
        if (popnow) begin
            m_cur    = mq.pop_front();
            m_active = 1'b1;
            m_pos    = 0;
        end else if (m_active) begin
            if (done) m_active = 1'b0;
            else      m_pos++;
        end
        if (acc) mq.push_back(int'(tx_data_c) & ((1 << c_db[sel]) - 1));
        @(negedge clk);
        if (chk) compare_all();
    endtask

    task automatic drain();
        for (int c = 0; c < 800 && (m_active || mq.size() != 0); c++) tick(1);
        tick(1);
        check("drained_idle", int'(obs_busy), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, max_cnt, b, ndone, busy_n, done_n;
        bit saw_block, started, acc;
        logic [11:0] cap;

        tbl[0] = '{2'd0, 9'h055, 40, 12'h2AA};
        tbl[1] = '{2'd1, 9'h007, 48, 12'hC0E};
        tbl[2] = '{2'd2, 9'h007, 48, 12'hE0E};
        tbl[3] = '{2'd3, 9'h1FB, 21, 12'h076};

        rst = 1'b1; tx_valid_c = 1'b0; tx_data_c = '0; sel = 2'd0;
        model_reset();
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            check("rst_bit_out", int'(obs_bit), 1);
            check("rst_busy", int'(obs_busy), 0);
            check("rst_isDone", int'(obs_done), 0);
            check("rst_tx_ready", int'(obs_ready), 1);
            check("rst_fifo_count", int'(obs_count), 0);
        end
        sel = 2'd0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        repeat (3) tick(1);

        // Single-frame vectors per configuration
        for (int i = 0; i < 4; i++) begin
            sel = tbl[i].sel;
            tx_data_c = tbl[i].word; tx_valid_c = 1'b1;
            tick(1);
            tx_valid_c = 1'b0;
            check("idle_one_edge_after_push", int'(obs_bit), 1);
            busy_n = 0; done_n = 0; cap = '0; started = 1'b0;
            for (int c = 0; c < 100; c++) begin
                tick(1);
                if (obs_busy) begin
                    if ((busy_n % c_cpb[sel]) == c_cpb[sel] / 2 && busy_n / c_cpb[sel] < 12)
                        cap[busy_n / c_cpb[sel]] = obs_bit;
                    if (obs_done) done_n++;
                    busy_n++;
                    started = 1'b1;
                end else if (started) begin
                    break;
                end
            end
            check("vec_frame_len", busy_n, tbl[i].flen);
            check("vec_done_pulses", done_n, 1);
            check("vec_serial", int'(cap), int'(tbl[i].serial));
        end

        // FIFO full with tx_valid held across six words
        sel = 2'd0;
        idx = 0; max_cnt = 0; saw_block = 1'b0; b = 0; ndone = 0; started = 1'b0;
        for (int c = 0; c < 400 && idx < 6; c++) begin
            tx_valid_c = 1'b1; tx_data_c = 9'(9'h0A0 + idx);
            acc = (mq.size() < 4);
            tick(1);
            if (acc) idx++;
            if (int'(obs_count) > max_cnt) max_cnt = int'(obs_count);
            if (!obs_ready) saw_block = 1'b1;
            if (obs_busy) begin b++; started = 1'b1; end
            if (obs_done) ndone++;
        end
        tx_valid_c = 1'b0;
        for (int c = 0; c < 400; c++) begin
            tick(1);
            if (!obs_busy && started) break;
            if (obs_busy) begin b++; started = 1'b1; end
            if (obs_done) ndone++;
        end
        check("full_words_accepted", idx, 6);
        check("full_max_count", max_cnt, 4);
        check("full_ready_dropped", int'(saw_block), 1);
        check("full_busy_no_gaps", b, 240);
        check("full_frames_done", ndone, 6);

        // Push on the isDone edge while one word is queued
        tx_valid_c = 1'b1; tx_data_c = 9'h0C3; tick(1);
        tx_data_c = 9'h03C; tick(1);
        tx_valid_c = 1'b0;
        for (int c = 0; c < 100 && !obs_done; c++) tick(1);
        check("pp_done_seen", int'(obs_done), 1);
        check("pp_count_before", int'(obs_count), 1);
        tx_valid_c = 1'b1; tx_data_c = 9'h0E7;
        tick(1);
        tx_valid_c = 1'b0;
        check("pp_count_after", int'(obs_count), 1);
        check("pp_busy", int'(obs_busy), 1);
        check("pp_start_immediate", int'(obs_bit), 0);
        drain();

        // Randomized traffic against the model, two configurations
        for (int s = 0; s < 2; s++) begin
            sel = (s == 0) ? 2'd0 : 2'd3;
            for (int c = 0; c < 1500; c++) begin
                tx_valid_c = ($urandom_range(0, 99) < 30);
                tx_data_c  = 9'($urandom);
                tick(1);
            end
            tx_valid_c = 1'b0;
            drain();
        end

        // Asynchronous reset in the middle of data bit 3
        sel = 2'd0;
        tx_valid_c = 1'b1; tx_data_c = 9'h0F0; tick(1);
        tx_data_c = 9'h033; tick(1);
        tx_valid_c = 1'b0;
        for (int c = 0; c < 60 && !(m_active && m_pos == 17); c++) tick(1);
        check("mid_data_bit3_low", int'(obs_bit), 0);
        check("mid_data_queued", int'(obs_count), 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_bit_out", int'(obs_bit), 1);
        check("async_rst_busy", int'(obs_busy), 0);
        check("async_rst_count", int'(obs_count), 0);
        check("async_rst_isDone", int'(obs_done), 0);
        check("async_rst_ready", int'(obs_ready), 1);
        model_reset();
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        repeat (12) tick(1);
        check("post_rst_idle", int'(obs_busy), 0);
        tx_valid_c = 1'b1; tx_data_c = 9'h05A; tick(1);
        tx_valid_c = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
